// File: rtl/ensemble_vote_n.sv
// ensemble_vote_n
//   Collects one single-beat class label from each enabled classifier stream.
//   It then takes a majority vote across the collected labels and emits one
//   result beat. If some enabled channels do not deliver a label in time, the
//   vote runs with whatever has arrived.
//
// Ports
//   clk, rst        : rising-edge clock, asynchronous active-high reset
//   s_axis_*        : NUM_CH input streams packed side by side (slice i = channel i);
//                     tkeep is ignored, every result is one beat
//   ch_enable       : mask of voting channels, sampled while idle in COLLECT
//   m_axis_*        : vote result stream
//                     tdata = {0, got[7:0], winner count[7:0], winner label}
//   sample_cnt      : results emitted (wraps)
//   timeout_cnt     : votes forced by timeout (saturates)
//   framing_err     : sticky, set by any accepted beat with tlast=0
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_COLLECT | accepting one label per enabled channel, timeout running
// S_VOTE    | one cycle: count agreement and register the winning result
// S_OUTPUT  | result valid on m_axis, held until m_axis_tready
module ensemble_vote_n #(
  parameter int NUM_CH      = 3,
  parameter int DATA_WIDTH  = 32,
  parameter int KEEP_WIDTH  = 4,
  parameter int CLASS_WIDTH = 8,
  parameter int TIMEOUT     = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_CH*KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [NUM_CH-1:0]            s_axis_tvalid,
  output logic [NUM_CH-1:0]            s_axis_tready,
  input  logic [NUM_CH-1:0]            s_axis_tlast,
  input  logic [NUM_CH-1:0]            ch_enable,
  output logic [DATA_WIDTH-1:0]        m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]        m_axis_tkeep,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tlast,
  output logic [15:0]                  sample_cnt,
  output logic [15:0]                  timeout_cnt,
  output logic                         framing_err
);

  typedef enum logic [1:0] {S_COLLECT, S_VOTE, S_OUTPUT} state_t;

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LOAD = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [NUM_CH-1:0]       r_en_q;
  logic [NUM_CH-1:0]       r_got;
  logic [CLASS_WIDTH-1:0]  r_label [NUM_CH];
  logic [TW-1:0]           r_tmo;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [15:0]             r_sample_cnt;
  logic [15:0]             r_timeout_cnt;
  logic                    r_framing_err;

  logic [NUM_CH-1:0]       w_fire;
  logic [NUM_CH-1:0]       w_got_nxt;
  logic                    w_complete;
  logic                    w_timeout;
  logic                    w_take_timeout;
  logic [7:0]              w_cnt [NUM_CH];
  logic [7:0]              w_best_cnt;
  logic [CLASS_WIDTH-1:0]  w_best_lbl;
  logic [DATA_WIDTH-1:0]   w_vote_data;
  logic                    w_unused;

  // Ignored inputs and the unused upper data bits are folded here.
  assign w_unused = ^{s_axis_tkeep, s_axis_tdata};

  assign s_axis_tready = (r_state == S_COLLECT) ? (r_en_q & ~r_got) : '0;
  assign w_fire        = s_axis_tvalid & s_axis_tready;
  assign w_got_nxt     = r_got | w_fire;

  // Completion looks at this cycle's captures so the last handshake reaches
  // VOTE on the very next edge (two-cycle handshake-to-valid latency).
  assign w_complete = (r_en_q != '0) && (w_got_nxt == r_en_q);
  assign w_timeout  = (TIMEOUT > 0) && (r_got != '0) && (r_tmo == '0);

  always_comb begin
    w_state_nxt    = r_state;
    w_take_timeout = 1'b0;
    case (r_state)
      S_COLLECT: begin
        if (w_complete) begin
          w_state_nxt = S_VOTE;
        end else if (w_timeout) begin
          w_state_nxt    = S_VOTE;
          w_take_timeout = 1'b1;
        end
      end
      S_VOTE:   w_state_nxt = S_OUTPUT;
      S_OUTPUT: if (m_axis_tready) w_state_nxt = S_COLLECT;
      default:  w_state_nxt = S_COLLECT;
    endcase
  end

  // Agreement count per collected channel.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_cnt[i] = '0;
      for (int j = 0; j < NUM_CH; j++) begin
        if (r_got[i] && r_got[j] && (r_label[j] == r_label[i]))
          w_cnt[i] = w_cnt[i] + 8'd1;
      end
    end
  end

  // Strict greater-than while scanning upward keeps the lowest index on ties.
  always_comb begin
    w_best_cnt = '0;
    w_best_lbl = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (r_got[i] && (w_cnt[i] > w_best_cnt)) begin
        w_best_cnt = w_cnt[i];
        w_best_lbl = r_label[i];
      end
    end
  end

  always_comb begin
    w_vote_data = '0;
    w_vote_data[CLASS_WIDTH-1:0]              = w_best_lbl;
    w_vote_data[CLASS_WIDTH+7:CLASS_WIDTH]    = w_best_cnt;
    w_vote_data[CLASS_WIDTH+15:CLASS_WIDTH+8] = 8'(r_got);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_COLLECT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_en_q        <= '0;
      r_got         <= '0;
      r_tmo         <= '0;
      r_data        <= '0;
      r_sample_cnt  <= '0;
      r_timeout_cnt <= '0;
      r_framing_err <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) r_label[i] <= '0;
    end else begin
      if (r_state == S_COLLECT) begin
        r_got <= w_got_nxt;
        // Enable mask tracks ch_enable until the first beat lands, then freezes.
        if ((r_got == '0) && (w_fire == '0)) r_en_q <= ch_enable;
        // Down-counter armed while idle; runs once any channel has delivered.
        if (r_got == '0) r_tmo <= TMO_LOAD;
        else if (r_tmo != '0) r_tmo <= r_tmo - TW'(1);
      end else begin
        r_tmo <= TMO_LOAD;
      end

      for (int i = 0; i < NUM_CH; i++) begin
        if (w_fire[i]) r_label[i] <= s_axis_tdata[i*DATA_WIDTH +: CLASS_WIDTH];
      end

      if ((w_fire & ~s_axis_tlast) != '0) r_framing_err <= 1'b1;

      if (w_take_timeout && (r_timeout_cnt != 16'hFFFF))
        r_timeout_cnt <= r_timeout_cnt + 16'd1;

      if (r_state == S_VOTE) r_data <= w_vote_data;

      if ((r_state == S_OUTPUT) && m_axis_tready) begin
        r_sample_cnt <= r_sample_cnt + 16'd1;
        r_got        <= '0;
      end
    end
  end

  assign m_axis_tdata  = r_data;
  assign m_axis_tkeep  = '1;
  assign m_axis_tvalid = (r_state == S_OUTPUT);
  assign m_axis_tlast  = m_axis_tvalid;
  assign sample_cnt    = r_sample_cnt;
  assign timeout_cnt   = r_timeout_cnt;
  assign framing_err   = r_framing_err;

endmodule

// File: tb/tb_ensemble_vote_n.sv
module tb_ensemble_vote_n;
  localparam int NUM_CH = 3;
  localparam int DW     = 32;
  localparam int KW     = 4;
  localparam int CW     = 8;
  localparam int TMO    = 16;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NUM_CH*DW-1:0] s_axis_tdata;
  logic [NUM_CH*KW-1:0] s_axis_tkeep;
  logic [NUM_CH-1:0]    s_axis_tvalid;
  logic [NUM_CH-1:0]    s_axis_tready;
  logic [NUM_CH-1:0]    s_axis_tlast;
  logic [NUM_CH-1:0]    ch_enable;
  logic [DW-1:0]        m_axis_tdata;
  logic [KW-1:0]        m_axis_tkeep;
  logic                 m_axis_tvalid;
  logic                 m_axis_tready;
  logic                 m_axis_tlast;
  logic [15:0]          sample_cnt;
  logic [15:0]          timeout_cnt;
  logic                 framing_err;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  ensemble_vote_n #(
    .NUM_CH(NUM_CH), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .CLASS_WIDTH(CW), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .ch_enable(ch_enable),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .sample_cnt(sample_cnt),
    .timeout_cnt(timeout_cnt), .framing_err(framing_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] v, input logic [7:0] l0, input logic [7:0] l1,
                       input logic [7:0] l2, input logic [2:0] last);
    s_axis_tdata  = {24'h0, l2, 24'h0, l1, 24'h0, l0};
    s_axis_tvalid = v;
    s_axis_tlast  = last;
  endtask

  initial begin
    s_axis_tkeep  = '1;
    ch_enable     = 3'b111;
    m_axis_tready = 1'b1;
    drive(3'b000, 8'h0, 8'h0, 8'h0, 3'b111);

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_ready",  32'(s_axis_tready), 32'h0);
    chk("rst_valid",  32'(m_axis_tvalid), 32'h0);
    chk("rst_data",   m_axis_tdata,       32'h0);
    chk("rst_scnt",   32'(sample_cnt),    32'h0);
    chk("rst_tcnt",   32'(timeout_cnt),   32'h0);
    chk("rst_ferr",   32'(framing_err),   32'h0);
    chk("rst_keep",   32'(m_axis_tkeep),  32'hF);
    rst = 1'b0;
    @(negedge clk);
    chk("en_load_ready", 32'(s_axis_tready), 32'h7);

    // labels 2,2,5 in one cycle
    drive(3'b111, 8'd2, 8'd2, 8'd5, 3'b111);
    @(negedge clk);
    drive(3'b000, 8'd0, 8'd0, 8'd0, 3'b111);
    chk("t1_vote_ready", 32'(s_axis_tready), 32'h0);
    chk("t1_t1_valid",   32'(m_axis_tvalid), 32'h0);
    @(negedge clk);
    chk("t1_valid", 32'(m_axis_tvalid), 32'h1);
    chk("t1_last",  32'(m_axis_tlast),  32'h1);
    chk("t1_data",  m_axis_tdata,       32'h00070202);
    @(negedge clk);
    chk("t1_scnt",  32'(sample_cnt),    32'h1);
    chk("t1_done_valid", 32'(m_axis_tvalid), 32'h0);
    chk("t1_reready", 32'(s_axis_tready), 32'h7);

    // staggered 1,4,7 -> three-way tie, lowest channel wins
    drive(3'b001, 8'd1, 8'd0, 8'd0, 3'b111);
    @(negedge clk);
    chk("t2_ready_after_ch0", 32'(s_axis_tready), 32'h6);
    drive(3'b010, 8'd0, 8'd4, 8'd0, 3'b111);
    @(negedge clk);
    chk("t2_ready_after_ch1", 32'(s_axis_tready), 32'h4);
    drive(3'b100, 8'd0, 8'd0, 8'd7, 3'b111);
    @(negedge clk);
    drive(3'b000, 8'd0, 8'd0, 8'd0, 3'b111);
    @(negedge clk);
    chk("t2_valid", 32'(m_axis_tvalid), 32'h1);
    chk("t2_data",  m_axis_tdata,       32'h00070101);
    @(negedge clk);
    chk("t2_scnt",  32'(sample_cnt),    32'h2);

    // timeout: channel 2 silent, channels 0,1 label 3; output held by backpressure
    m_axis_tready = 1'b0;
    drive(3'b011, 8'd3, 8'd3, 8'd0, 3'b111);
    @(negedge clk);
    drive(3'b000, 8'd0, 8'd0, 8'd0, 3'b111);
    chk("t3_ready_partial", 32'(s_axis_tready), 32'h4);
    for (int k = 2; k <= 17; k++) @(negedge clk);
    chk("t3_not_yet_valid", 32'(m_axis_tvalid), 32'h0);
    @(negedge clk);
    chk("t3_valid", 32'(m_axis_tvalid), 32'h1);
    chk("t3_data",  m_axis_tdata,       32'h00030203);
    chk("t3_tcnt",  32'(timeout_cnt),   32'h1);

    // backpressure for 10 cycles with inputs offering new labels
    drive(3'b111, 8'd8, 8'd8, 8'd8, 3'b111);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_data",  m_axis_tdata,       32'h00030203);
      chk("bp_ready", 32'(s_axis_tready), 32'h0);
      chk("bp_valid", 32'(m_axis_tvalid), 32'h1);
    end
    drive(3'b000, 8'd0, 8'd0, 8'd0, 3'b111);
    m_axis_tready = 1'b1;
    @(negedge clk);
    chk("bp_scnt",    32'(sample_cnt),    32'h3);
    chk("bp_reready", 32'(s_axis_tready), 32'h7);
    chk("bp_tcnt",    32'(timeout_cnt),   32'h1);

    // ch_enable 101: channel 1 never ready; channel 0 beat has tlast=0
    ch_enable = 3'b101;
    @(negedge clk);
    chk("t4_ready", 32'(s_axis_tready), 32'h5);
    drive(3'b111, 8'd6, 8'd9, 8'd6, 3'b110);
    @(negedge clk);
    drive(3'b000, 8'd0, 8'd0, 8'd0, 3'b111);
    @(negedge clk);
    chk("t4_valid", 32'(m_axis_tvalid), 32'h1);
    chk("t4_data",  m_axis_tdata,       32'h00050206);
    chk("t4_ferr",  32'(framing_err),   32'h1);
    @(negedge clk);
    chk("t4_scnt",  32'(sample_cnt),    32'h4);

    // reset after one capture discards the partial sample
    ch_enable = 3'b111;
    @(negedge clk);
    drive(3'b001, 8'd9, 8'd0, 8'd0, 3'b111);
    @(negedge clk);
    drive(3'b000, 8'd0, 8'd0, 8'd0, 3'b111);
    chk("t5_partial_ready", 32'(s_axis_tready), 32'h6);
    rst = 1'b1;
    #1;
    chk("t5_rst_ready", 32'(s_axis_tready), 32'h0);
    chk("t5_rst_valid", 32'(m_axis_tvalid), 32'h0);
    chk("t5_rst_data",  m_axis_tdata,       32'h0);
    chk("t5_rst_scnt",  32'(sample_cnt),    32'h0);
    chk("t5_rst_tcnt",  32'(timeout_cnt),   32'h0);
    chk("t5_rst_ferr",  32'(framing_err),   32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_fresh_ready", 32'(s_axis_tready), 32'h7);
    drive(3'b110, 8'd0, 8'd4, 8'd4, 3'b111);
    @(negedge clk);
    chk("t5_no_early_vote", 32'(s_axis_tready), 32'h1);
    drive(3'b001, 8'd4, 8'd0, 8'd0, 3'b111);
    @(negedge clk);
    drive(3'b000, 8'd0, 8'd0, 8'd0, 3'b111);
    @(negedge clk);
    chk("t5_valid", 32'(m_axis_tvalid), 32'h1);
    chk("t5_data",  m_axis_tdata,       32'h00070304);
    @(negedge clk);
    chk("t5_scnt",  32'(sample_cnt),    32'h1);
    chk("t5_ferr",  32'(framing_err),   32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
